// File: rtl/tl_pkg.sv
// Shared transaction-layer types: stream/command/completion payloads, TLP
// header field encodings and the receive-side request FSM state.
package tl_pkg;

  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [2:0] FMT_4DW_DATA   = 3'b011;

  localparam logic [4:0] TYPE_MRD   = 5'b00000;
  localparam logic [4:0] TYPE_MRDLK = 5'b00001;
  localparam logic [4:0] TYPE_IO    = 5'b00010;
  localparam logic [4:0] TYPE_CFG0  = 5'b00100;
  localparam logic [4:0] TYPE_CFG1  = 5'b00101;
  // Type[4:3] of every message TLP (routing lives in Type[2:0])
  localparam logic [1:0] TYPE_MSG_PFX = 2'b10;

  typedef struct packed {
    logic [127:0] data;
    logic         sop;
    logic         eop;
    logic         is_dllp;
  } tl_stream_t;

  typedef enum logic {
    CMD_MEM = 1'b0,
    CMD_CFG = 1'b1
  } tl_cmd_type_e;

  typedef struct packed {
    tl_cmd_type_e cmd_type;
    logic         wr_en;
    logic [9:0]   len;
    logic [3:0]   be;
    logic [63:0]  addr;
    logic [7:0]   bus;
    logic [4:0]   device;
    logic [2:0]   function_num;
    logic [9:0]   reg_num;
  } tl_cmd_t;

  typedef struct packed {
    logic [127:0] data;
    logic         last;
  } tl_data_t;

  typedef enum logic [2:0] {
    CPL_SC = 3'b000,
    CPL_UR = 3'b001,
    CPL_CA = 3'b100
  } cpl_status_e;

  typedef struct packed {
    cpl_status_e  status;
    logic         has_data;
    logic [11:0]  byte_count;
    logic [6:0]   lower_addr;
    logic [15:0]  requester_id;
    logic [7:0]   tag;
    logic [255:0] data;
  } cpl_gen_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ISSUE,
    WAIT_RD,
    CPL
  } tl_req_state_e;

  typedef enum logic [1:0] {
    REQ_DROP,
    REQ_ISSUE,
    REQ_UR
  } tl_req_class_e;

endpackage

// File: rtl/tl_byte_count_calc.sv
// Completion byte_count / lower_addr for a memory read, derived from the
// request Length, byte enables and the low address bits.
module tl_byte_count_calc (
  input  logic [9:0]  len,
  input  logic [3:0]  first_be,
  input  logic [3:0]  last_be,
  input  logic [4:0]  addr_lo,
  output logic [11:0] byte_count,
  output logic [6:0]  lower_addr
);

  logic [1:0] lo_idx;
  logic [1:0] hi_idx;

  always_comb begin
    lo_idx = 2'd0;
    if      (first_be[0]) lo_idx = 2'd0;
    else if (first_be[1]) lo_idx = 2'd1;
    else if (first_be[2]) lo_idx = 2'd2;
    else if (first_be[3]) lo_idx = 2'd3;
  end

  // An empty LastBE trims nothing from the tail
  always_comb begin
    hi_idx = 2'd3;
    if      (last_be[3]) hi_idx = 2'd3;
    else if (last_be[2]) hi_idx = 2'd2;
    else if (last_be[1]) hi_idx = 2'd1;
    else if (last_be[0]) hi_idx = 2'd0;
  end

  always_comb begin
    byte_count = 12'd1;
    if (len == 10'd1) begin
      casez (first_be)
        4'b1??1:                   byte_count = 12'd4;
        4'b01?1, 4'b1?10:          byte_count = 12'd3;
        4'b0011, 4'b0110, 4'b1100: byte_count = 12'd2;
        default:                   byte_count = 12'd1;
      endcase
    end else begin
      byte_count = {len, 2'b00} - 12'(lo_idx) - 12'(2'd3 - hi_idx);
    end
  end

  assign lower_addr = {addr_lo, lo_idx};

endmodule

// File: rtl/tl_rx_req_responder.sv
// Receive-side non-posted request responder: decodes MRd/CfgRd0/CfgWr0,
// drives the user bus, and hands one completion request per NP TLP onward.
module tl_rx_req_responder
  import tl_pkg::*;
#(
  parameter int unsigned MAX_RD_DW   = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  tl_stream_t   rx,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  output tl_cmd_t      cmd,
  output logic [31:0]  cmd_wdata,
  input  logic         rd_valid,
  input  tl_data_t     rd,
  output logic         cpl_valid,
  input  logic         cpl_ready,
  output cpl_gen_cmd_t cpl,
  output logic [15:0]  stat_drop
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  tl_req_state_e state_q, state_d, pend_q;
  logic          rx_ready_q, cmd_valid_q, cpl_valid_q;
  logic          rx_ready_d, cmd_valid_d, cpl_valid_d;
  tl_cmd_t       cmd_q, dec_cmd;
  logic [31:0]   cmd_wdata_q;
  cpl_gen_cmd_t  cpl_q;
  logic [15:0]   drop_q;
  logic [TW-1:0] tmo_cnt;
  logic [1:0]    beat_idx;

  logic          rx_fire, sop_fire, cmd_fire, cpl_fire, rd_done, tmo_hit;
  logic [31:0]   dw0, dw1, dw2, dw3;
  logic [2:0]    fmt;
  logic [4:0]    typ;
  logic [9:0]    len;
  logic [3:0]    first_be, last_be;
  logic          is_mem_rd, is_cfg_rd, is_cfg_wr, is_msg, len_ok;
  logic [63:0]   mem_addr;
  tl_req_class_e req_class;
  tl_req_state_e dec_target;
  logic [11:0]   bc_calc;
  logic [6:0]    la_calc;
  logic          unused_hdr_bits;

  assign dw0      = rx.data[31:0];
  assign dw1      = rx.data[63:32];
  assign dw2      = rx.data[95:64];
  assign dw3      = rx.data[127:96];
  assign fmt      = dw0[31:29];
  assign typ      = dw0[28:24];
  assign len      = dw0[9:0];
  assign first_be = dw1[3:0];
  assign last_be  = dw1[7:4];
  assign unused_hdr_bits = ^dw0[23:10];

  assign rx_fire  = rx_valid && rx_ready_q;
  assign sop_fire = rx_fire && !rx.is_dllp && rx.sop;
  assign cmd_fire = cmd_valid_q && cmd_ready;
  assign cpl_fire = cpl_valid_q && cpl_ready;
  assign rd_done  = rd_valid && rd.last;
  assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYC - 1)) && !rd_done;

  assign is_mem_rd = ((fmt == FMT_3DW_NODATA) || (fmt == FMT_4DW_NODATA)) && (typ == TYPE_MRD);
  assign is_cfg_rd = (fmt == FMT_3DW_NODATA) && (typ == TYPE_CFG0);
  assign is_cfg_wr = (fmt == FMT_3DW_DATA) && (typ == TYPE_CFG0);
  assign is_msg    = (typ[4:3] == TYPE_MSG_PFX);
  assign len_ok    = (len != 10'd0) && (len <= 10'(MAX_RD_DW));
  assign mem_addr  = (fmt == FMT_4DW_NODATA) ? {dw2, dw3[31:2], 2'b00}
                                             : {32'b0, dw2[31:2], 2'b00};

  // Fmt bit 30 clear means no payload, so anything else non-posted is a request we must answer
  always_comb begin
    req_class = REQ_DROP;
    if (is_msg)
      req_class = REQ_DROP;
    else if ((is_mem_rd && len_ok) || is_cfg_rd || is_cfg_wr)
      req_class = REQ_ISSUE;
    else if (!fmt[1] || (typ == TYPE_IO) || (typ == TYPE_CFG0) || (typ == TYPE_CFG1))
      req_class = REQ_UR;
  end

  assign dec_target = (req_class == REQ_UR) ? CPL : ISSUE;

  always_comb begin
    dec_cmd       = '0;
    dec_cmd.wr_en = is_cfg_wr;
    dec_cmd.be    = first_be;
    if (is_mem_rd) begin
      dec_cmd.cmd_type = CMD_MEM;
      dec_cmd.len      = len;
      dec_cmd.addr     = mem_addr;
    end else begin
      dec_cmd.cmd_type     = CMD_CFG;
      dec_cmd.len          = 10'd1;
      dec_cmd.bus          = dw2[31:24];
      dec_cmd.device       = dw2[23:19];
      dec_cmd.function_num = dw2[18:16];
      dec_cmd.reg_num      = dw2[11:2];
    end
  end

  tl_byte_count_calc u_bc (
    .len        (len),
    .first_be   (first_be),
    .last_be    (last_be),
    .addr_lo    (mem_addr[6:2]),
    .byte_count (bc_calc),
    .lower_addr (la_calc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cpl_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      cmd_valid_q <= cmd_valid_d;
      cpl_valid_q <= cpl_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (sop_fire) begin
          if (!rx.eop)                     state_d = DRAIN;
          else if (req_class != REQ_DROP)  state_d = dec_target;
        end
      end
      DRAIN:   if (rx_fire && !rx.is_dllp && rx.eop) state_d = pend_q;
      ISSUE:   if (cmd_fire) state_d = cmd_q.wr_en ? CPL : WAIT_RD;
      WAIT_RD: if (rd_done || tmo_hit) state_d = CPL;
      CPL:     if (cpl_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Valids are registered from the next state so they are clean flop outputs
  always_comb begin
    rx_ready_d  = (state_d == IDLE) || (state_d == DRAIN);
    cmd_valid_d = (state_d == ISSUE);
    cpl_valid_d = (state_d == CPL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= IDLE;
      cmd_q       <= '0;
      cmd_wdata_q <= '0;
      cpl_q       <= '0;
      drop_q      <= '0;
      tmo_cnt     <= '0;
      beat_idx    <= '0;
    end else begin
      if ((rx_fire && rx.is_dllp) || (state_q == IDLE && sop_fire && req_class == REQ_DROP))
        drop_q <= drop_q + 16'd1;

      if (state_q == IDLE && sop_fire) begin
        // Posted TLPs only drain; they must not disturb a payload already presented
        pend_q <= (req_class == REQ_DROP) ? IDLE : dec_target;
        if (req_class != REQ_DROP) begin
          cpl_q.requester_id <= dw1[31:16];
          cpl_q.tag          <= dw1[15:8];
          cpl_q.data         <= '0;
          cpl_q.has_data     <= 1'b0;
          cpl_q.status       <= (req_class == REQ_UR) ? CPL_UR : CPL_SC;
          if (req_class == REQ_ISSUE && is_mem_rd) begin
            cpl_q.byte_count <= bc_calc;
            cpl_q.lower_addr <= la_calc;
          end else begin
            cpl_q.byte_count <= 12'd4;
            cpl_q.lower_addr <= '0;
          end
        end
        if (req_class == REQ_ISSUE) begin
          cmd_q       <= dec_cmd;
          cmd_wdata_q <= is_cfg_wr ? dw3 : '0;
        end
      end

      if (state_q == ISSUE && cmd_fire) begin
        tmo_cnt  <= '0;
        beat_idx <= '0;
      end

      if (state_q == WAIT_RD) begin
        tmo_cnt <= tmo_cnt + TW'(1);
        if (rd_valid) begin
          if (beat_idx == 2'd0) cpl_q.data[127:0]   <= rd.data;
          if (beat_idx == 2'd1) cpl_q.data[255:128] <= rd.data;
          if (beat_idx != 2'd2) beat_idx <= beat_idx + 2'd1;
        end
        if (rd_done) begin
          cpl_q.status   <= CPL_SC;
          cpl_q.has_data <= 1'b1;
        end else if (tmo_hit) begin
          cpl_q.status   <= CPL_CA;
          cpl_q.has_data <= 1'b0;
          cpl_q.data     <= '0;
        end
      end
    end
  end

  assign rx_ready  = rx_ready_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign cmd_wdata = cmd_wdata_q;
  assign cpl_valid = cpl_valid_q;
  assign cpl       = cpl_q;
  assign stat_drop = drop_q;

endmodule

// File: tb/tb_tl_rx_req_responder.sv
// Directed bench for tl_rx_req_responder with hand-computed expectations.
module tb_tl_rx_req_responder;
  import tl_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_valid;
  logic         rx_ready;
  tl_stream_t   rx;
  logic         cmd_valid;
  logic         cmd_ready;
  tl_cmd_t      cmd;
  logic [31:0]  cmd_wdata;
  logic         rd_valid;
  tl_data_t     rd;
  logic         cpl_valid;
  logic         cpl_ready;
  cpl_gen_cmd_t cpl;
  logic [15:0]  stat_drop;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  tl_rx_req_responder #(
    .MAX_RD_DW   (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx        (rx),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .cmd_wdata (cmd_wdata),
    .rd_valid  (rd_valid),
    .rd        (rd),
    .cpl_valid (cpl_valid),
    .cpl_ready (cpl_ready),
    .cpl       (cpl),
    .stat_drop (stat_drop)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_dw0(input logic [2:0] f, input logic [4:0] t, input logic [9:0] l);
    return {f, t, 14'b0, l};
  endfunction

  function automatic logic [31:0] mk_dw1(input logic [15:0] rid, input logic [7:0] tag,
                                         input logic [3:0] lbe, input logic [3:0] fbe);
    return {rid, tag, lbe, fbe};
  endfunction

  task automatic send(input logic [127:0] d, input logic sop, input logic eop, input logic dllp);
    check("rx_ready_before_beat", 256'(rx_ready), 256'(1));
    rx_valid   = 1'b1;
    rx.data    = d;
    rx.sop     = sop;
    rx.eop     = eop;
    rx.is_dllp = dllp;
    step();
    rx_valid = 1'b0;
    rx       = '0;
  endtask

  task automatic cmd_accept();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
  endtask

  task automatic cpl_accept();
    cpl_ready = 1'b1;
    step();
    cpl_ready = 1'b0;
  endtask

  task automatic rd_beat(input logic [127:0] d, input logic last);
    rd_valid = 1'b1;
    rd.data  = d;
    rd.last  = last;
    step();
    rd_valid = 1'b0;
    rd       = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d0, d1;
    int           tmo_seen;

    d0 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    d1 = 128'hf0e0d0c0_b0a09080_70605040_30201000;
    rst = 1'b1; rx_valid = 1'b0; rx = '0; cmd_ready = 1'b0;
    rd_valid = 1'b0; rd = '0; cpl_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_rx_ready", 256'(rx_ready), 256'(0));
    check("rst_cmd_valid", 256'(cmd_valid), 256'(0));
    check("rst_cpl_valid", 256'(cpl_valid), 256'(0));
    check("rst_cmd", 256'(cmd), 256'(0));
    check("rst_cmd_wdata", 256'(cmd_wdata), 256'(0));
    check("rst_cpl_status", 256'(cpl.status), 256'(0));
    check("rst_cpl_data", cpl.data, 256'(0));
    check("rst_stat_drop", 256'(stat_drop), 256'(0));
    rst = 1'b0;
    step();
    check("post_rst_rx_ready", 256'(rx_ready), 256'(1));

    // 3DW MRd, Length 2, FirstBE F, LastBE 3, two read beats
    send({32'h0, 32'h1000_0044, mk_dw1(16'hABCD, 8'h15, 4'h3, 4'hF), mk_dw0(3'b000, 5'b00000, 10'd2)}, 1'b1, 1'b1, 1'b0);
    check("mrd_cmd_valid", 256'(cmd_valid), 256'(1));
    check("mrd_rx_ready_busy", 256'(rx_ready), 256'(0));
    check("mrd_cmd_type", 256'(cmd.cmd_type), 256'(CMD_MEM));
    check("mrd_cmd_wr_en", 256'(cmd.wr_en), 256'(0));
    check("mrd_cmd_len", 256'(cmd.len), 256'(2));
    check("mrd_cmd_be", 256'(cmd.be), 256'(4'hF));
    check("mrd_cmd_addr", 256'(cmd.addr), 256'(64'h1000_0044));
    step();
    check("mrd_cmd_valid_held", 256'(cmd_valid), 256'(1));
    cmd_accept();
    check("mrd_cmd_valid_drop", 256'(cmd_valid), 256'(0));
    rd_beat(d0, 1'b0);
    check("mrd_cpl_not_yet", 256'(cpl_valid), 256'(0));
    rd_beat(d1, 1'b1);
    check("mrd_cpl_valid", 256'(cpl_valid), 256'(1));
    check("mrd_cpl_status", 256'(cpl.status), 256'(CPL_SC));
    check("mrd_cpl_has_data", 256'(cpl.has_data), 256'(1));
    check("mrd_cpl_byte_count", 256'(cpl.byte_count), 256'(6));
    check("mrd_cpl_lower_addr", 256'(cpl.lower_addr), 256'(7'h44));
    check("mrd_cpl_tag", 256'(cpl.tag), 256'(8'h15));
    check("mrd_cpl_rid", 256'(cpl.requester_id), 256'(16'hABCD));
    check("mrd_cpl_data", cpl.data, {d1, d0});
    step();
    check("mrd_cpl_valid_held", 256'(cpl_valid), 256'(1));
    cpl_accept();
    check("mrd_cpl_valid_drop", 256'(cpl_valid), 256'(0));
    check("mrd_back_idle", 256'(rx_ready), 256'(1));

    // 4DW MRd split over two beats, Length 1, FirstBE 0110, one read beat
    send({32'h2345_6788, 32'h0000_0001, mk_dw1(16'h0042, 8'h07, 4'h0, 4'b0110), mk_dw0(3'b001, 5'b00000, 10'd1)}, 1'b1, 1'b0, 1'b0);
    check("mrd4_draining_no_cmd", 256'(cmd_valid), 256'(0));
    send(128'h5a5a, 1'b0, 1'b1, 1'b0);
    check("mrd4_cmd_valid", 256'(cmd_valid), 256'(1));
    check("mrd4_cmd_addr", 256'(cmd.addr), 256'(64'h0000_0001_2345_6788));
    check("mrd4_cmd_len", 256'(cmd.len), 256'(1));
    cmd_accept();
    rd_beat(d0, 1'b1);
    check("mrd4_cpl_valid", 256'(cpl_valid), 256'(1));
    check("mrd4_cpl_byte_count", 256'(cpl.byte_count), 256'(2));
    check("mrd4_cpl_lower_addr", 256'(cpl.lower_addr), 256'(7'h09));
    check("mrd4_cpl_data", cpl.data, {128'h0, d0});
    cpl_accept();

    // CfgWr0 bus 1 dev 2 fn 0 reg 0x10
    send({32'hDEAD_BEEF, {8'h01, 5'd2, 3'd0, 4'h0, 10'h010, 2'b00},
          mk_dw1(16'h0100, 8'h22, 4'h0, 4'hF), mk_dw0(3'b010, 5'b00100, 10'd1)}, 1'b1, 1'b1, 1'b0);
    check("cfgwr_cmd_valid", 256'(cmd_valid), 256'(1));
    check("cfgwr_cmd_type", 256'(cmd.cmd_type), 256'(CMD_CFG));
    check("cfgwr_cmd_wr_en", 256'(cmd.wr_en), 256'(1));
    check("cfgwr_cmd_len", 256'(cmd.len), 256'(1));
    check("cfgwr_cmd_bus", 256'(cmd.bus), 256'(1));
    check("cfgwr_cmd_device", 256'(cmd.device), 256'(2));
    check("cfgwr_cmd_fn", 256'(cmd.function_num), 256'(0));
    check("cfgwr_cmd_reg", 256'(cmd.reg_num), 256'(10'h010));
    check("cfgwr_cmd_wdata", 256'(cmd_wdata), 256'(32'hDEAD_BEEF));
    cmd_accept();
    check("cfgwr_cpl_valid", 256'(cpl_valid), 256'(1));
    check("cfgwr_cpl_status", 256'(cpl.status), 256'(CPL_SC));
    check("cfgwr_cpl_has_data", 256'(cpl.has_data), 256'(0));
    check("cfgwr_cpl_byte_count", 256'(cpl.byte_count), 256'(4));
    check("cfgwr_cpl_tag", 256'(cpl.tag), 256'(8'h22));
    cpl_accept();

    // MRd Length 16 and Length 0 are answered with UR
    send({32'h0, 32'h2000_0000, mk_dw1(16'h0011, 8'h31, 4'hF, 4'hF), mk_dw0(3'b000, 5'b00000, 10'd16)}, 1'b1, 1'b1, 1'b0);
    check("len16_no_cmd", 256'(cmd_valid), 256'(0));
    check("len16_cpl_valid", 256'(cpl_valid), 256'(1));
    check("len16_cpl_status", 256'(cpl.status), 256'(CPL_UR));
    check("len16_cpl_byte_count", 256'(cpl.byte_count), 256'(4));
    check("len16_cpl_tag", 256'(cpl.tag), 256'(8'h31));
    cpl_accept();
    send({32'h0, 32'h2000_0004, mk_dw1(16'h0011, 8'h32, 4'h0, 4'hF), mk_dw0(3'b000, 5'b00000, 10'd0)}, 1'b1, 1'b1, 1'b0);
    check("len0_no_cmd", 256'(cmd_valid), 256'(0));
    check("len0_cpl_status", 256'(cpl.status), 256'(CPL_UR));
    check("len0_cpl_has_data", 256'(cpl.has_data), 256'(0));
    check("len0_cpl_lower_addr", 256'(cpl.lower_addr), 256'(0));
    cpl_accept();

    // 3-beat MWr then a DLLP: both dropped, nothing issued
    send({32'h0, 32'h3000_0000, mk_dw1(16'h0011, 8'h00, 4'hF, 4'hF), mk_dw0(3'b010, 5'b00000, 10'd6)}, 1'b1, 1'b0, 1'b0);
    send(128'h1111, 1'b0, 1'b0, 1'b0);
    send(128'h2222, 1'b0, 1'b1, 1'b0);
    send(128'h3333, 1'b1, 1'b1, 1'b1);
    check("drop_count_2", 256'(stat_drop), 256'(2));
    check("drop_no_cmd", 256'(cmd_valid), 256'(0));
    check("drop_no_cpl", 256'(cpl_valid), 256'(0));
    send({96'h0, mk_dw0(3'b001, 5'b10100, 10'd0)}, 1'b1, 1'b1, 1'b0);
    check("drop_msg_count", 256'(stat_drop), 256'(3));
    send(128'h4444, 1'b0, 1'b1, 1'b0);
    check("orphan_beat_not_counted", 256'(stat_drop), 256'(3));

    // CfgRd0 with no read data: CA 16 cycles after the cmd handshake
    send({32'h0, {8'h03, 5'd1, 3'd2, 4'h0, 10'h004, 2'b00},
          mk_dw1(16'h0100, 8'h44, 4'h0, 4'hF), mk_dw0(3'b000, 5'b00100, 10'd1)}, 1'b1, 1'b1, 1'b0);
    check("cfgrd_cmd_type", 256'(cmd.cmd_type), 256'(CMD_CFG));
    check("cfgrd_cmd_wr_en", 256'(cmd.wr_en), 256'(0));
    check("cfgrd_cmd_bus", 256'(cmd.bus), 256'(3));
    check("cfgrd_cmd_fn", 256'(cmd.function_num), 256'(2));
    cmd_accept();
    tmo_seen = 0;
    for (int i = 1; i <= 40 && tmo_seen == 0; i++) begin
      step();
      if (cpl_valid) tmo_seen = i;
    end
    check("tmo_cycles", 256'(tmo_seen), 256'(16));
    check("tmo_cpl_status", 256'(cpl.status), 256'(CPL_CA));
    check("tmo_cpl_has_data", 256'(cpl.has_data), 256'(0));
    rd_beat(d0, 1'b1);
    check("tmo_late_rd_data", cpl.data, 256'(0));
    check("tmo_late_rd_status", 256'(cpl.status), 256'(CPL_CA));
    cpl_accept();
    rd_beat(d1, 1'b1);
    check("idle_rd_no_cpl", 256'(cpl_valid), 256'(0));
    check("idle_rd_rx_ready", 256'(rx_ready), 256'(1));

    // CfgWr1 gets UR; reset pulse while the completion is stalled
    send({32'h0, 32'h0100_0000, mk_dw1(16'h0100, 8'h55, 4'h0, 4'hF), mk_dw0(3'b010, 5'b00101, 10'd1)}, 1'b1, 1'b1, 1'b0);
    check("cfg1_cpl_status", 256'(cpl.status), 256'(CPL_UR));
    step(); step(); step(); step();
    check("cfg1_cpl_valid_stalled", 256'(cpl_valid), 256'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_cpl_valid", 256'(cpl_valid), 256'(0));
    check("midrst_stat_drop", 256'(stat_drop), 256'(0));
    step();
    check("midrst_rx_ready", 256'(rx_ready), 256'(1));
    step(); step(); step();
    check("midrst_no_cpl", 256'(cpl_valid), 256'(0));
    check("midrst_no_cmd", 256'(cmd_valid), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
